// File: rtl/clock_pkg.sv
// Shared constants and helpers for the HH:MM:SS clock: field selects, field limits,
// 7-segment patterns ({g,f,e,d,c,b,a}, active high) and small arithmetic helpers.
package clock_pkg;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_SEC  = 2'b01;
   localparam logic [1:0] SEL_MIN  = 2'b10;
   localparam logic [1:0] SEL_HOUR = 2'b11;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [5:0] HOUR_MAX = 6'd23;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // Step a field by one within 0..max_v, wrapping at both ends.
   function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                            input logic up);
      if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
      return (v == 6'd0) ? max_v : v - 6'd1;
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to a 7-segment code {g,f,e,d,c,b,a}; non-decimal codes are blank.
module seg7_decode
   import clock_pkg::*;
#(
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   logic [6:0] pattern;

   assign pattern = seg_pattern(bcd);
   assign seg     = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;

endmodule

// File: rtl/rtc_hms_clock.sv
// 24-hour HH:MM:SS clock with 1 Hz divider, per-field edit, 12/24-hour display and
// 7-segment outputs. Define ALARM_EN to build the armed alarm with sticky ring.
module rtc_hms_clock
   import clock_pkg::*;
#(
   parameter int CLK_HZ         = 1000,
   parameter int DIV_W          = 10,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_en,
   input  logic [1:0]  set_sel,
   input  logic        inc,
   input  logic        dec,
   input  logic        h12_mode,
   input  logic        alarm_edit,
   input  logic        alarm_arm,
   input  logic        alarm_ack,
   output logic [23:0] time_bcd,
   output logic        pm,
   output logic [41:0] seg,
   output logic        tick_1hz,
   output logic        alarm_ring
);

   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_HZ - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       sec_q, sec_d, min_q, min_d;
   logic [4:0]       hour_q, hour_d;
   logic             tick_q, tick_d;
   logic             inc_prev_q, dec_prev_q;
   logic             inc_rise, dec_rise, step_any, advance, edit_alarm;
   logic [5:0]       disp_hour;

   always_comb begin
      inc_rise = inc & ~inc_prev_q;
      dec_rise = dec & ~dec_prev_q;
      step_any = inc_rise ^ dec_rise;
      div_d    = div_q;
      sec_d    = sec_q;
      min_d    = min_q;
      hour_d   = hour_q;
      tick_d   = 1'b0;
      advance  = 1'b0;
      if (!set_en) begin
         if (div_q == DIV_TC) begin
            div_d   = '0;
            tick_d  = 1'b1;
            advance = 1'b1;
            sec_d   = wrap_step(sec_q, SEC_MAX, 1'b1);
            if (sec_q == SEC_MAX) begin
               min_d = wrap_step(min_q, MIN_MAX, 1'b1);
               if (min_q == MIN_MAX) hour_d = 5'(wrap_step({1'b0, hour_q}, HOUR_MAX, 1'b1));
            end
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end else begin
         // Edits wrap inside the selected field only; no carry into neighbours.
         div_d = '0;
         if (step_any && !edit_alarm) begin
            case (set_sel)
               SEL_SEC:  sec_d  = wrap_step(sec_q, SEC_MAX, inc_rise);
               SEL_MIN:  min_d  = wrap_step(min_q, MIN_MAX, inc_rise);
               SEL_HOUR: hour_d = 5'(wrap_step({1'b0, hour_q}, HOUR_MAX, inc_rise));
               default:  ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         hour_q     <= '0;
         tick_q     <= 1'b0;
         inc_prev_q <= 1'b0;
         dec_prev_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         tick_q     <= tick_d;
         inc_prev_q <= inc;
         dec_prev_q <= dec;
      end
   end

`ifdef ALARM_EN
   logic [5:0] alarm_min_q, alarm_min_d;
   logic [4:0] alarm_hour_q, alarm_hour_d;
   logic       ring_q, ring_d;

   assign edit_alarm = alarm_edit;

   // A match on a time advance beats a same-cycle acknowledge.
   always_comb begin
      alarm_min_d  = alarm_min_q;
      alarm_hour_d = alarm_hour_q;
      ring_d       = ring_q;
      if (set_en && alarm_edit && step_any) begin
         if (set_sel == SEL_MIN)
            alarm_min_d = wrap_step(alarm_min_q, MIN_MAX, inc_rise);
         else if (set_sel == SEL_HOUR)
            alarm_hour_d = 5'(wrap_step({1'b0, alarm_hour_q}, HOUR_MAX, inc_rise));
      end
      if (alarm_ack) ring_d = 1'b0;
      if (advance && alarm_arm && sec_d == 6'd0 && min_d == alarm_min_q && hour_d == alarm_hour_q)
         ring_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_min_q  <= '0;
         alarm_hour_q <= '0;
         ring_q       <= 1'b0;
      end else begin
         alarm_min_q  <= alarm_min_d;
         alarm_hour_q <= alarm_hour_d;
         ring_q       <= ring_d;
      end
   end

   assign alarm_ring = ring_q;
`else
   logic unused_alarm;

   assign edit_alarm   = 1'b0;
   assign unused_alarm = ^{alarm_edit, alarm_arm, alarm_ack};
   assign alarm_ring   = 1'b0;
`endif

   always_comb begin
      disp_hour = {1'b0, hour_q};
      if (h12_mode) begin
         if (hour_q == 5'd0 || hour_q == 5'd12) disp_hour = 6'd12;
         else if (hour_q > 5'd12)               disp_hour = {1'b0, hour_q - 5'd12};
      end
   end

   assign time_bcd = {to_bcd(disp_hour), to_bcd(min_q), to_bcd(sec_q)};
   assign pm       = (hour_q >= 5'd12);
   assign tick_1hz = tick_q;

   for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
         .bcd (time_bcd[4*gi +: 4]),
         .seg (seg[7*gi +: 7])
      );
   end

endmodule

// File: tb/tb_rtc_hms_clock.sv
// Bench for rtc_hms_clock at CLK_HZ = 10: directed scenarios plus random stimulus
// against a seconds-of-day reference model.
module tb_rtc_hms_clock;

   localparam int CLK_HZ = 10;
   localparam int DIV_W  = 4;
`ifdef ALARM_EN
   localparam bit ALARM_BUILD = 1'b1;
`else
   localparam bit ALARM_BUILD = 1'b0;
`endif

   logic        clk;
   logic        rst, set_en, inc, dec, h12_mode, alarm_edit, alarm_arm, alarm_ack;
   logic [1:0]  set_sel;
   logic [23:0] time_bcd;
   logic        pm, tick_1hz, alarm_ring;
   logic [41:0] seg;

   int vectors;
   int miscompares;

   // Reference model: time of day as plain seconds since midnight.
   int m_t, m_div, m_al_h, m_al_m;
   bit m_tick, m_ring, m_inc_prev, m_dec_prev;

   rtc_hms_clock #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W), .SEG_ACTIVE_LOW(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .set_en     (set_en),
      .set_sel    (set_sel),
      .inc        (inc),
      .dec        (dec),
      .h12_mode   (h12_mode),
      .alarm_edit (alarm_edit),
      .alarm_arm  (alarm_arm),
      .alarm_ack  (alarm_ack),
      .time_bcd   (time_bcd),
      .pm         (pm),
      .seg        (seg),
      .tick_1hz   (tick_1hz),
      .alarm_ring (alarm_ring)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [23:0] exp_bcd(input int t, input bit h12);
      int h, mi, s;
      h  = t / 3600;
      mi = (t / 60) % 60;
      s  = t % 60;
      if (h12) h = (h % 12 == 0) ? 12 : h % 12;
      return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [41:0] exp_seg(input int t, input bit h12);
      logic [23:0] b;
      logic [41:0] r;
      b = exp_bcd(t, h12);
      for (int i = 0; i < 6; i++) r[7*i +: 7] = digit_seg(b[4*i +: 4]);
      return r;
   endfunction

   task automatic model_step();
      bit ir, dr, hit;
      int h, mi, s, d;
      if (rst) begin
         m_t = 0; m_div = 0; m_tick = 0; m_ring = 0;
         m_al_h = 0; m_al_m = 0; m_inc_prev = 0; m_dec_prev = 0;
         return;
      end
      ir = inc && !m_inc_prev;
      dr = dec && !m_dec_prev;
      m_inc_prev = inc;
      m_dec_prev = dec;
      m_tick = 0;
      hit = 0;
      if (!set_en) begin
         if (m_div == CLK_HZ - 1) begin
            m_div  = 0;
            m_t    = (m_t + 1) % 86400;
            m_tick = 1;
            hit    = alarm_arm && (m_t % 60 == 0) && (m_t / 60 == m_al_h * 60 + m_al_m);
         end else begin
            m_div++;
         end
      end else begin
         m_div = 0;
         if (ir != dr) begin
            d  = ir ? 1 : -1;
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (ALARM_BUILD && alarm_edit) begin
               if (set_sel == 2'd2)      m_al_m = (m_al_m + d + 60) % 60;
               else if (set_sel == 2'd3) m_al_h = (m_al_h + d + 24) % 24;
            end else begin
               case (set_sel)
                  2'd1:    s  = (s + d + 60) % 60;
                  2'd2:    mi = (mi + d + 60) % 60;
                  2'd3:    h  = (h + d + 24) % 24;
                  default: ;
               endcase
            end
            m_t = h * 3600 + mi * 60 + s;
         end
      end
      if (ALARM_BUILD) begin
         if (alarm_ack) m_ring = 0;
         if (hit)       m_ring = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press_inc();
      inc = 1'b1;
      step();
      inc = 1'b0;
      step();
   endtask

   task automatic set_field(input int sel, input int target, input bit to_alarm);
      int cur;
      set_en     = 1'b1;
      alarm_edit = to_alarm;
      set_sel    = 2'(sel);
      for (int n = 0; n < 60; n++) begin
         if (to_alarm) cur = (sel == 3) ? m_al_h : m_al_m;
         else          cur = (sel == 3) ? m_t / 3600 : (sel == 2) ? (m_t / 60) % 60 : m_t % 60;
         if (cur == target) break;
         press_inc();
      end
   endtask

   task automatic set_time(input int h, input int mi, input int s);
      set_field(3, h, 1'b0);
      set_field(2, mi, 1'b0);
      set_field(1, s, 1'b0);
   endtask

   task automatic set_alarm(input int h, input int mi);
      set_field(3, h, 1'b1);
      set_field(2, mi, 1'b1);
      alarm_edit = 1'b0;
   endtask

   task automatic test_reset();
      logic [41:0] e;
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++; if (time_bcd !== 24'h000000) begin miscompares++; $display("FAIL reset_bcd: got %h expected 000000", time_bcd); end
      vectors++; if (pm !== 1'b0) begin miscompares++; $display("FAIL reset_pm: got %b expected 0", pm); end
      vectors++; if (tick_1hz !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", tick_1hz); end
      vectors++; if (alarm_ring !== 1'b0) begin miscompares++; $display("FAIL reset_ring: got %b expected 0", alarm_ring); end
      e = exp_seg(0, 1'b0);
      vectors++; if (seg !== e) begin miscompares++; $display("FAIL reset_seg24: got %h expected %h", seg, e); end
      h12_mode = 1'b1;
      #1;
      e = exp_seg(0, 1'b1);
      vectors++; if (seg !== e) begin miscompares++; $display("FAIL reset_seg12: got %h expected %h", seg, e); end
      vectors++; if (time_bcd[23:16] !== 8'h12) begin miscompares++; $display("FAIL reset_hour12: got %h expected 12", time_bcd[23:16]); end
      h12_mode = 1'b0;
   endtask

   task automatic test_first_tick();
      int ticks;
      rst = 1'b1;
      step();
      rst = 1'b0;
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         ticks += int'(tick_1hz);
      end
      vectors++; if (ticks != 1 || tick_1hz !== 1'b1) begin miscompares++; $display("FAIL first_tick_count: got %0d (last %b) expected 1 on cycle 10", ticks, tick_1hz); end
      vectors++; if (time_bcd !== 24'h000001) begin miscompares++; $display("FAIL first_tick_bcd: got %h expected 000001", time_bcd); end
      vectors++; if (seg[6:0] !== 7'b0000110) begin miscompares++; $display("FAIL first_tick_seg: got %b expected 0000110", seg[6:0]); end
   endtask

   task automatic test_rollover();
      set_time(23, 59, 58);
      set_en = 1'b0;
      steps(10);
      vectors++; if (time_bcd !== 24'h235959 || pm !== 1'b1) begin miscompares++; $display("FAIL rollover_235959: got %h pm %b expected 235959 pm 1", time_bcd, pm); end
      steps(10);
      vectors++; if (time_bcd !== 24'h000000 || pm !== 1'b0) begin miscompares++; $display("FAIL rollover_000000: got %h pm %b expected 000000 pm 0", time_bcd, pm); end
   endtask

   task automatic test_edit_wrap();
      set_time(1, 7, 59);
      set_sel = 2'b01;
      inc = 1'b1;
      step();
      vectors++; if (time_bcd !== 24'h010700) begin miscompares++; $display("FAIL edit_inc_wrap: got %h expected 010700", time_bcd); end
      inc = 1'b0;
      step();
      dec = 1'b1;
      step();
      vectors++; if (time_bcd !== 24'h010759) begin miscompares++; $display("FAIL edit_dec_wrap: got %h expected 010759", time_bcd); end
      dec = 1'b0;
      step();
      inc = 1'b1;
      steps(5);
      inc = 1'b0;
      step();
      vectors++; if (time_bcd !== 24'h010700) begin miscompares++; $display("FAIL edit_hold_inc: got %h expected 010700", time_bcd); end
      inc = 1'b1;
      dec = 1'b1;
      step();
      inc = 1'b0;
      dec = 1'b0;
      step();
      vectors++; if (time_bcd !== 24'h010700) begin miscompares++; $display("FAIL edit_inc_dec_same: got %h expected 010700", time_bcd); end
      set_sel = 2'b00;
      press_inc();
      vectors++; if (time_bcd !== 24'h010700) begin miscompares++; $display("FAIL edit_sel_none: got %h expected 010700", time_bcd); end
   endtask

   task automatic test_h12();
      h12_mode = 1'b1;
      set_time(0, 7, 0);
      vectors++; if (time_bcd[23:16] !== 8'h12 || pm !== 1'b0) begin miscompares++; $display("FAIL h12_midnight: got %h pm %b expected 12 pm 0", time_bcd[23:16], pm); end
      set_field(3, 13, 1'b0);
      vectors++; if (time_bcd[23:16] !== 8'h01 || pm !== 1'b1) begin miscompares++; $display("FAIL h12_13h: got %h pm %b expected 01 pm 1", time_bcd[23:16], pm); end
      vectors++; if (seg[41:28] !== {7'b0111111, 7'b0000110}) begin miscompares++; $display("FAIL h12_13h_seg: got %b expected 01111110000110", seg[41:28]); end
      set_field(3, 12, 1'b0);
      vectors++; if (time_bcd[23:16] !== 8'h12 || pm !== 1'b1) begin miscompares++; $display("FAIL h12_noon: got %h pm %b expected 12 pm 1", time_bcd[23:16], pm); end
      h12_mode = 1'b0;
      #1;
      vectors++; if (time_bcd[23:16] !== 8'h12) begin miscompares++; $display("FAIL h24_noon: got %h expected 12", time_bcd[23:16]); end
   endtask

`ifdef ALARM_EN
   task automatic test_alarm();
      alarm_arm = 1'b0;
      set_time(0, 0, 50);
      set_alarm(0, 1);
      alarm_arm = 1'b1;
      set_en = 1'b0;
      steps(99);
      vectors++; if (alarm_ring !== 1'b0) begin miscompares++; $display("FAIL alarm_early: got %b expected 0", alarm_ring); end
      step();
      vectors++; if (alarm_ring !== 1'b1 || time_bcd !== 24'h000100) begin miscompares++; $display("FAIL alarm_set: got ring %b time %h expected 1 000100", alarm_ring, time_bcd); end
      alarm_arm = 1'b0;
      steps(12);
      vectors++; if (alarm_ring !== 1'b1) begin miscompares++; $display("FAIL alarm_sticky: got %b expected 1", alarm_ring); end
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      vectors++; if (alarm_ring !== 1'b0) begin miscompares++; $display("FAIL alarm_ack: got %b expected 0", alarm_ring); end
      set_alarm(0, 2);
      set_time(0, 1, 59);
      vectors++; if (alarm_ring !== 1'b0) begin miscompares++; $display("FAIL alarm_edit_no_ring: got %b expected 0", alarm_ring); end
      alarm_arm = 1'b1;
      set_en = 1'b0;
      steps(9);
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      vectors++; if (alarm_ring !== 1'b1 || time_bcd !== 24'h000200) begin miscompares++; $display("FAIL alarm_set_beats_ack: got ring %b time %h expected 1 000200", alarm_ring, time_bcd); end
   endtask
`else
   task automatic test_alarm_absent();
      set_time(0, 0, 59);
      alarm_edit = 1'b1;
      alarm_arm  = 1'b1;
      set_sel    = 2'b01;
      press_inc();
      vectors++; if (time_bcd !== 24'h000000) begin miscompares++; $display("FAIL noalarm_edit_time: got %h expected 000000", time_bcd); end
      set_en = 1'b0;
      steps(10);
      vectors++; if (alarm_ring !== 1'b0 || time_bcd !== 24'h000001) begin miscompares++; $display("FAIL noalarm_ring: got ring %b time %h expected 0 000001", alarm_ring, time_bcd); end
      alarm_edit = 1'b0;
      alarm_arm  = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      int early;
`ifdef ALARM_EN
      set_time(12, 33, 59);
      set_alarm(12, 34);
      alarm_arm = 1'b1;
      set_en = 1'b0;
      steps(10);
      set_field(1, 56, 1'b0);
      vectors++; if (alarm_ring !== 1'b1) begin miscompares++; $display("FAIL reset_mid_ring_pre: got %b expected 1", alarm_ring); end
`else
      set_time(12, 34, 56);
`endif
      vectors++; if (time_bcd !== 24'h123456) begin miscompares++; $display("FAIL reset_mid_pre: got %h expected 123456", time_bcd); end
      set_en = 1'b0;
      steps(5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      alarm_arm = 1'b0;
      vectors++; if (time_bcd !== 24'h000000 || pm !== 1'b0 || alarm_ring !== 1'b0 || tick_1hz !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_clear: got %h pm %b ring %b tick %b expected 000000 0 0 0", time_bcd, pm, alarm_ring, tick_1hz); end
      early = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         early += int'(tick_1hz);
      end
      step();
      vectors++; if (early != 0 || tick_1hz !== 1'b1) begin miscompares++; $display("FAIL reset_mid_next_tick: got %0d early ticks, tick %b expected 0 then 1", early, tick_1hz); end
   endtask

   task automatic test_random();
      logic [23:0] eb;
      logic [41:0] es;
      for (int i = 0; i < 500; i++) begin
         rst        = ($urandom_range(0, 149) == 0);
         set_en     = ($urandom_range(0, 4) == 0);
         set_sel    = 2'($urandom_range(0, 3));
         inc        = ($urandom_range(0, 2) == 0);
         dec        = ($urandom_range(0, 2) == 0);
         h12_mode   = 1'($urandom_range(0, 1));
         alarm_edit = 1'($urandom_range(0, 1));
         alarm_arm  = 1'($urandom_range(0, 1));
         alarm_ack  = ($urandom_range(0, 7) == 0);
         step();
         eb = exp_bcd(m_t, h12_mode);
         es = exp_seg(m_t, h12_mode);
         vectors++; if (time_bcd !== eb) begin miscompares++; $display("FAIL rand_bcd[%0d]: got %h expected %h", i, time_bcd, eb); end
         vectors++; if (pm !== (m_t >= 43200)) begin miscompares++; $display("FAIL rand_pm[%0d]: got %b expected %b", i, pm, m_t >= 43200); end
         vectors++; if (seg !== es) begin miscompares++; $display("FAIL rand_seg[%0d]: got %h expected %h", i, seg, es); end
         vectors++; if (tick_1hz !== m_tick) begin miscompares++; $display("FAIL rand_tick[%0d]: got %b expected %b", i, tick_1hz, m_tick); end
         vectors++; if (alarm_ring !== m_ring) begin miscompares++; $display("FAIL rand_ring[%0d]: got %b expected %b", i, alarm_ring, m_ring); end
      end
      rst = 1'b0; set_en = 1'b0; inc = 1'b0; dec = 1'b0;
      alarm_edit = 1'b0; alarm_arm = 1'b0; alarm_ack = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1; set_en = 1'b0; set_sel = 2'b00; inc = 1'b0; dec = 1'b0;
      h12_mode = 1'b0; alarm_edit = 1'b0; alarm_arm = 1'b0; alarm_ack = 1'b0;
      test_reset();
      test_first_tick();
      test_rollover();
      test_edit_wrap();
      test_h12();
`ifdef ALARM_EN
      test_alarm();
`else
      test_alarm_absent();
`endif
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
